// File: rtl/frogger_game_fsm_if.sv
// Game sequencer handshake bundle: per-frame inputs from collision/tile logic and
// registered status outputs toward the frog controller and renderer.
interface frogger_game_fsm_if;
   logic       frame_tick;
   logic       start;
   logic       collision;
   logic [5:0] frogger_y;
   logic       game_active;
   logic       frog_respawn;
   logic [6:0] score;
   logic [1:0] lives;
   logic [2:0] level;
   logic       hit_flash;
   logic [2:0] state;

   modport master (
      output frame_tick, start, collision, frogger_y,
      input  game_active, frog_respawn, score, lives, level, hit_flash, state
   );

   modport slave (
      input  frame_tick, start, collision, frogger_y,
      output game_active, frog_respawn, score, lives, level, hit_flash, state
   );
endinterface

// File: rtl/frogger_game_fsm.sv
// Frogger game lifecycle sequencer: score, lives, level, respawn and movement gating.
// Latency: every output is registered and updates on the edge entering a state; no backpressure.
module frogger_game_fsm #(
   parameter int START_LIVES     = 3,
   parameter int GOAL_ROW        = 0,
   parameter int HIT_FRAMES      = 60,
   parameter int GOAL_FRAMES     = 30,
   parameter int GOALS_PER_LEVEL = 5,
   parameter int SCORE_MAX       = 99
) (
   input  logic               clk,
   input  logic               rst,
   frogger_game_fsm_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PLAYING = 3'd1,
      S_HIT     = 3'd2,
      S_GOAL    = 3'd3,
      S_OVER    = 3'd4
   } state_t;

   localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
   localparam logic [5:0] GOAL_Y     = 6'(GOAL_ROW);
   localparam logic [7:0] HIT_LIM    = 8'(HIT_FRAMES);
   localparam logic [7:0] GOAL_LIM   = 8'(GOAL_FRAMES);
   localparam logic [3:0] GOAL_LVL   = 4'(GOALS_PER_LEVEL);
   localparam logic [6:0] SCORE_SAT  = 7'(SCORE_MAX);
   localparam logic [2:0] LEVEL_SAT  = 3'd7;

   state_t     state_q,   state_d;
   logic [6:0] score_q,   score_d;
   logic [1:0] lives_q,   lives_d;
   logic [2:0] level_q,   level_d;
   logic [3:0] goal_q,    goal_d;
   logic [7:0] frame_q,   frame_d;
   logic       respawn_q, respawn_d;
   logic       active_q,  active_d;
   logic       flash_q,   flash_d;
   logic       start_prev_q;

   logic       start_edge;
   logic [7:0] frame_inc;
   logic [3:0] goal_inc;

   assign start_edge = bus.start & ~start_prev_q;
   assign frame_inc  = frame_q + 8'd1;
   assign goal_inc   = goal_q + 4'd1;

   // start_prev comes out of reset high so a held button cannot launch a game
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         score_q      <= 7'd0;
         lives_q      <= LIVES_INIT;
         level_q      <= 3'd0;
         goal_q       <= 4'd0;
         frame_q      <= 8'd0;
         respawn_q    <= 1'b0;
         active_q     <= 1'b0;
         flash_q      <= 1'b0;
         start_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
         level_q      <= level_d;
         goal_q       <= goal_d;
         frame_q      <= frame_d;
         respawn_q    <= respawn_d;
         active_q     <= active_d;
         flash_q      <= flash_d;
         start_prev_q <= bus.start;
      end
   end

   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      lives_d   = lives_q;
      level_d   = level_q;
      goal_d    = goal_q;
      frame_d   = frame_q;
      respawn_d = 1'b0;

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_edge) begin
               state_d   = S_PLAYING;
               score_d   = 7'd0;
               lives_d   = LIVES_INIT;
               level_d   = 3'd0;
               goal_d    = 4'd0;
               respawn_d = 1'b1;
            end
         end
         S_PLAYING: begin
            // collision outranks a simultaneous arrival at the goal row
            if (bus.collision) begin
               state_d = S_HIT;
               frame_d = 8'd0;
               if (lives_q != 2'd0) begin
                  lives_d = lives_q - 2'd1;
               end
            end else if (bus.frogger_y == GOAL_Y) begin
               state_d = S_GOAL;
               frame_d = 8'd0;
               if (score_q < SCORE_SAT) begin
                  score_d = score_q + 7'd1;
               end
            end
         end
         S_HIT: begin
            if (bus.frame_tick) begin
               frame_d = frame_inc;
               if (frame_inc == HIT_LIM) begin
                  if (lives_q == 2'd0) begin
                     state_d = S_OVER;
                  end else begin
                     state_d   = S_PLAYING;
                     respawn_d = 1'b1;
                  end
               end
            end
         end
         S_GOAL: begin
            if (bus.frame_tick) begin
               frame_d = frame_inc;
               if (frame_inc == GOAL_LIM) begin
                  state_d   = S_PLAYING;
                  respawn_d = 1'b1;
                  if (goal_inc == GOAL_LVL) begin
                     goal_d = 4'd0;
                     if (level_q != LEVEL_SAT) begin
                        level_d = level_q + 3'd1;
                     end
                  end else begin
                     goal_d = goal_inc;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      active_d = (state_d == S_PLAYING);
      flash_d  = (state_d == S_HIT);
   end

   assign bus.state        = state_q;
   assign bus.score        = score_q;
   assign bus.lives        = lives_q;
   assign bus.level        = level_q;
   assign bus.frog_respawn = respawn_q;
   assign bus.game_active  = active_q;
   assign bus.hit_flash    = flash_q;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Self-checking bench for frogger_game_fsm: directed scenarios plus random play
// against a rule-level game model.
module tb_frogger_game_fsm;
   logic clk;
   logic rst;
   frogger_game_fsm_if ifc();

   frogger_game_fsm dut (.clk(clk), .rst(rst), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // model: mode 0 idle, 1 playing, 2 hit, 3 goal, 4 over
   int m_mode, m_score, m_lives, m_level, m_goals, m_dwell;
   bit m_prev, m_resp;

   logic [17:0] dut_vec;
   assign dut_vec = {ifc.state, ifc.score, ifc.lives, ifc.level,
                     ifc.game_active, ifc.hit_flash, ifc.frog_respawn};

   function automatic logic [17:0] exp_vec();
      logic [2:0] s; logic [6:0] sc; logic [1:0] lv; logic [2:0] lvl;
      s = 3'(m_mode); sc = 7'(m_score); lv = 2'(m_lives); lvl = 3'(m_level);
      return {s, sc, lv, lvl, m_mode == 1, m_mode == 2, m_resp};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_score = 0; m_lives = 3; m_level = 0;
      m_goals = 0; m_dwell = 0; m_prev = 1'b1; m_resp = 1'b0;
   endtask

   task automatic model_step(bit ft, bit st, bit col, int y);
      bit edge_seen;
      edge_seen = st && !m_prev;
      m_prev = st;
      m_resp = 1'b0;
      if (m_mode == 0 || m_mode == 4) begin
         if (edge_seen) begin
            m_mode = 1; m_score = 0; m_lives = 3; m_level = 0; m_goals = 0; m_resp = 1'b1;
         end
      end else if (m_mode == 1) begin
         if (col) begin
            m_mode = 2; m_dwell = 0; m_lives = (m_lives > 0) ? m_lives - 1 : 0;
         end else if (y == 0) begin
            m_mode = 3; m_dwell = 0; m_score = (m_score < 99) ? m_score + 1 : 99;
         end
      end else if (m_mode == 2 && ft) begin
         m_dwell++;
         if (m_dwell == 60) begin
            if (m_lives == 0) m_mode = 4;
            else begin m_mode = 1; m_resp = 1'b1; end
         end
      end else if (m_mode == 3 && ft) begin
         m_dwell++;
         if (m_dwell == 30) begin
            m_mode = 1; m_resp = 1'b1; m_goals++;
            if (m_goals == 5) begin
               m_goals = 0; m_level = (m_level < 7) ? m_level + 1 : 7;
            end
         end
      end
   endtask

   // one clock: drive at negedge, advance the model on the edge, settle 1 time unit
   task automatic cyc(bit ft, bit st, bit col, int y);
      @(negedge clk);
      ifc.frame_tick = ft; ifc.start = st; ifc.collision = col; ifc.frogger_y = 6'(y);
      @(posedge clk);
      model_step(ft, st, col, y);
      #1;
   endtask

   task automatic test_reset();
      ifc.frame_tick = 0; ifc.start = 1; ifc.collision = 0; ifc.frogger_y = 6'd14;
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dut_vec !== 18'({3'd0, 7'd0, 2'd3, 3'd0, 3'b000})) begin
         fails++; $display("FAIL reset_values: got %h want %h", dut_vec, {3'd0, 7'd0, 2'd3, 3'd0, 3'b000});
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0, 14);
         checks++;
         if (ifc.state !== 3'd0 || ifc.frog_respawn !== 1'b0) begin
            fails++; $display("FAIL held_start: state=%0d respawn=%0b want 0/0", ifc.state, ifc.frog_respawn);
         end
      end
      cyc(0, 0, 0, 14);
      cyc(0, 1, 0, 14);
      checks++;
      if (ifc.state !== 3'd1 || ifc.frog_respawn !== 1'b1 || ifc.lives !== 2'd3 ||
          ifc.score !== 7'd0 || ifc.game_active !== 1'b1) begin
         fails++; $display("FAIL start_edge: got %h want state1 resp1 lives3 score0", dut_vec);
      end
      cyc(0, 1, 0, 14);
      checks++;
      if (ifc.frog_respawn !== 1'b0) begin
         fails++; $display("FAIL respawn_width: respawn=%0b want 0", ifc.frog_respawn);
      end
   endtask

   task automatic test_goal();
      cyc(1, 0, 0, 0);
      checks++;
      if (ifc.state !== 3'd3 || ifc.score !== 7'd1 || ifc.game_active !== 1'b0) begin
         fails++; $display("FAIL goal_entry: state=%0d score=%0d active=%0b want 3/1/0",
                           ifc.state, ifc.score, ifc.game_active);
      end
      for (int i = 1; i <= 30; i++) begin
         cyc(1, 0, 1, 14);   // collision must be ignored during the goal dwell
         checks++;
         if (dut_vec !== exp_vec()) begin
            fails++; $display("FAIL goal_dwell tick %0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      checks++;
      if (ifc.state !== 3'd1 || ifc.frog_respawn !== 1'b1) begin
         fails++; $display("FAIL goal_exit: state=%0d respawn=%0b want 1/1", ifc.state, ifc.frog_respawn);
      end
   endtask

   task automatic test_hit();
      cyc(0, 0, 1, 14);
      checks++;
      if (ifc.state !== 3'd2 || ifc.lives !== 2'd2 || ifc.hit_flash !== 1'b1) begin
         fails++; $display("FAIL hit_entry: state=%0d lives=%0d flash=%0b want 2/2/1",
                           ifc.state, ifc.lives, ifc.hit_flash);
      end
      for (int i = 1; i <= 59; i++) cyc(1, 0, 1, 0);
      checks++;
      if (ifc.state !== 3'd2) begin
         fails++; $display("FAIL hit_59: state=%0d want 2", ifc.state);
      end
      cyc(1, 0, 0, 14);
      checks++;
      if (ifc.state !== 3'd1 || ifc.frog_respawn !== 1'b1 || ifc.hit_flash !== 1'b0) begin
         fails++; $display("FAIL hit_60: state=%0d respawn=%0b want 1/1", ifc.state, ifc.frog_respawn);
      end
   endtask

   task automatic test_priority();
      cyc(0, 0, 1, 0);
      checks++;
      if (ifc.state !== 3'd2 || ifc.score !== 7'd1 || ifc.lives !== 2'd1) begin
         fails++; $display("FAIL col_vs_goal: state=%0d score=%0d lives=%0d want 2/1/1",
                           ifc.state, ifc.score, ifc.lives);
      end
      for (int i = 0; i < 60; i++) cyc(1, 0, 0, 14);
      checks++;
      if (dut_vec !== exp_vec()) begin
         fails++; $display("FAIL priority_recover: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_game_over();
      int budget;
      for (int g = 0; g < 2; g++) begin
         budget = 0;
         while (m_mode != 4 && budget < 400) begin
            budget++;
            cyc(1, 0, m_mode == 1, 14);
            checks++;
            if (dut_vec !== exp_vec()) begin
               fails++; $display("FAIL over_seq g%0d: got %h want %h", g, dut_vec, exp_vec());
            end
         end
         checks++;
         if (ifc.state !== 3'd4 || ifc.frog_respawn !== 1'b0 || ifc.lives !== 2'd0) begin
            fails++; $display("FAIL over_entry g%0d: state=%0d resp=%0b lives=%0d want 4/0/0",
                              g, ifc.state, ifc.frog_respawn, ifc.lives);
         end
         cyc(0, 0, 0, 14);
         cyc(0, 1, 0, 14);
         checks++;
         if (ifc.state !== 3'd1 || ifc.lives !== 2'd3 || ifc.score !== 7'd0 || ifc.frog_respawn !== 1'b1) begin
            fails++; $display("FAIL restart g%0d: got %h want state1 lives3 score0 resp1", g, dut_vec);
         end
         cyc(0, 0, 0, 14);
      end
   endtask

   task automatic test_level_and_saturation();
      for (int g = 1; g <= 100; g++) begin
         cyc(0, 0, 0, 0);
         for (int t = 0; t < 30; t++) cyc(1, 0, 0, 14);
         checks++;
         if (dut_vec !== exp_vec()) begin
            fails++; $display("FAIL goal_loop %0d: got %h want %h", g, dut_vec, exp_vec());
         end
         if (g == 5) begin
            checks++;
            if (ifc.level !== 3'd1) begin
               fails++; $display("FAIL level_up: level=%0d want 1", ifc.level);
            end
         end
      end
      checks++;
      if (ifc.score !== 7'd99 || ifc.level !== 3'd7) begin
         fails++; $display("FAIL saturate: score=%0d level=%0d want 99/7", ifc.score, ifc.level);
      end
   endtask

   task automatic test_reset_mid_hit();
      cyc(0, 0, 1, 14);
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 14);
      #2 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
         fails++; $display("FAIL reset_mid_hit: got %h want %h", dut_vec, exp_vec());
      end
      @(negedge clk); rst = 1'b0;
      cyc(0, 0, 0, 14);
      checks++;
      if (dut_vec !== exp_vec()) begin
         fails++; $display("FAIL after_reset: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      bit ft, st, col;
      int y;
      for (int i = 0; i < 4000; i++) begin
         ft  = ($urandom_range(0, 2) != 0);
         st  = ($urandom_range(0, 5) == 0);
         col = ($urandom_range(0, 20) == 0);
         y   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 14);
         cyc(ft, st, col, y);
         checks++;
         if (dut_vec !== exp_vec()) begin
            fails++; $display("FAIL random cycle %0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_goal();
      test_hit();
      test_priority();
      test_game_over();
      test_level_and_saturation();
      test_reset_mid_hit();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end
endmodule
